iffifo_byte_packer: RTL and testbench

Byte-to-word packer that sits directly upstream of the inter-FIFO (iffifo) write path. Collects an 8-bit valid/ready byte stream (UART/SPI-style peripheral) into little-endian 32-bit words and presents them on a valid/ready word port. The word port drives the FIFO write side or a DMA source. Partial words are closed by end-of-packet, software flush, or an idle timeout, so trailing bytes are never stranded.

---
 rtl/iffifo_byte_packer.sv | 128 ++++++++++++
 tb/tb_iffifo_byte_packer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iffifo_byte_packer.sv
// iffifo_byte_packer: collects a valid/ready byte stream into little-endian
// 32-bit words for the iffifo write path. Partial words are closed by
// end-of-packet, a flush request or an idle timeout. A word that closes while
// the output register is still occupied waits in the accumulator (PENDING),
// which stalls the byte side until the output slot frees up.

module iffifo_byte_packer #(
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 byte_valid_i,
    output logic                 byte_ready_o,
    input  logic [7:0]           byte_data_i,
    input  logic                 byte_last_i,
    input  logic                 flush_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic                 word_valid_o,
    input  logic                 word_ready_i,
    output logic [31:0]          word_data_o,
    output logic [2:0]           word_nbytes_o
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_PENDING = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [3:0][7:0]      acc_q, acc_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0] idle_q, idle_d;
    logic                 wvalid_q, wvalid_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [2:0]           wnb_q, wnb_d;

    logic                 pending;
    logic                 accept;
    logic                 pop;
    logic                 slot_free;
    logic                 expiry;
    logic                 close;
    logic [3:0][7:0]      next_acc;
    logic [2:0]           next_cnt;

    // A closed word parked in the accumulator blocks further bytes.
    assign pending      = (state_q == ST_PENDING);
    assign byte_ready_o = !pending;
    assign accept       = byte_valid_i & byte_ready_o;
    assign pop          = wvalid_q & word_ready_i;
    assign slot_free    = !wvalid_q | word_ready_i;

    assign word_valid_o  = wvalid_q;
    assign word_data_o   = wdata_q;
    assign word_nbytes_o = wnb_q;

    // Merge the incoming byte at lane 'count' and decide whether the word closes.
    // Accept implies count <= 3: a count of 4 only survives an edge as PENDING.
    always_comb begin
        next_acc = acc_q;
        if (accept) begin
            next_acc[cnt_q[1:0]] = byte_data_i;
        end
        next_cnt = cnt_q + {2'b00, accept};
        expiry   = (timeout_i != '0) && (cnt_q != 3'd0) && !accept &&
                   (idle_q == (timeout_i - TIMEOUT_W'(1)));
        close    = (next_cnt == 3'd4) ||
                   (accept && byte_last_i) ||
                   (flush_i && (next_cnt != 3'd0)) ||
                   expiry ||
                   pending;
    end

    // Next-state for accumulator, output register, idle counter and state.
    always_comb begin
        acc_d    = next_acc;
        cnt_d    = next_cnt;
        state_d  = (next_cnt == 3'd0) ? ST_EMPTY : ST_FILLING;
        wvalid_d = wvalid_q & !pop;
        wdata_d  = wdata_q;
        wnb_d    = wnb_q;

        if (close && slot_free) begin
            // Lanes above the final count are already zero because the
            // accumulator is cleared every time a word leaves it.
            wvalid_d = 1'b1;
            wdata_d  = next_acc;
            wnb_d    = next_cnt;
            acc_d    = '0;
            cnt_d    = 3'd0;
            state_d  = ST_EMPTY;
        end else if (close) begin
            state_d  = ST_PENDING;
        end

        // Idle counter only runs while a partial word is open and unblocked.
        if (accept || (cnt_q == 3'd0)) begin
            idle_d = '0;
        end else if (!pending) begin
            idle_d = idle_q + TIMEOUT_W'(1);
        end else begin
            idle_d = idle_q;
        end
    end

    // State and registered outputs; reset discards any held or pending bytes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_EMPTY;
            acc_q    <= '0;
            cnt_q    <= 3'd0;
            idle_q   <= '0;
            wvalid_q <= 1'b0;
            wdata_q  <= '0;
            wnb_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            wvalid_q <= wvalid_d;
            wdata_q  <= wdata_d;
            wnb_q    <= wnb_d;
        end
    end

endmodule

// File: tb/tb_iffifo_byte_packer.sv
// Testbench for iffifo_byte_packer: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.

module tb_iffifo_byte_packer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic [7:0]  byte_data_i;
    logic        byte_last_i;
    logic        flush_i;
    logic [15:0] timeout_i;
    logic        word_valid_o;
    logic        word_ready_i;
    logic [31:0] word_data_o;
    logic [2:0]  word_nbytes_o;

    int checks = 0;
    int errors = 0;

    iffifo_byte_packer #(.TIMEOUT_W(16)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .byte_valid_i  (byte_valid_i),
        .byte_ready_o  (byte_ready_o),
        .byte_data_i   (byte_data_i),
        .byte_last_i   (byte_last_i),
        .flush_i       (flush_i),
        .timeout_i     (timeout_i),
        .word_valid_o  (word_valid_o),
        .word_ready_i  (word_ready_i),
        .word_data_o   (word_data_o),
        .word_nbytes_o (word_nbytes_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: open bytes as a queue, plus output slot contents.
    logic [7:0]  mq[$];
    bit          m_pend = 0;
    bit          m_wv   = 0;
    logic [31:0] m_wd   = '0;
    int          m_nb   = 0;
    logic [15:0] m_idle = '0;

    function automatic logic [31:0] pack(input logic [7:0] q[$]);
        logic [31:0] r = '0;
        foreach (q[k]) r = r | (32'(q[k]) << (8 * k));
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        bit acc, pop, free, expd, close;
        logic [7:0] nq[$];
        if (!rst_ni) begin
            mq.delete();
            m_pend = 0; m_idle = '0; m_wv = 0; m_wd = '0; m_nb = 0;
            return;
        end
        acc  = byte_valid_i && !m_pend;
        pop  = m_wv && word_ready_i;
        free = !m_wv || word_ready_i;
        nq   = mq;
        if (acc) nq.push_back(byte_data_i);
        expd = (timeout_i != 0) && (mq.size() > 0) && !acc &&
               (m_idle == 16'(timeout_i - 16'd1));
        close = (nq.size() == 4) || (acc && byte_last_i) ||
                (flush_i && nq.size() > 0) || expd || m_pend;
        if (acc || mq.size() == 0) m_idle = '0;
        else if (!m_pend)          m_idle = m_idle + 16'd1;
        if (pop) m_wv = 0;
        if (close && free) begin
            m_wv = 1; m_wd = pack(nq); m_nb = nq.size();
            mq.delete(); m_pend = 0;
        end else begin
            mq = nq;
            if (close) m_pend = 1;
        end
    endtask

    // One clock: model follows the edge, then DUT is compared #1 after it.
    task automatic step();
        model_edge();
        @(posedge clk_i);
        #1;
        chk("model_byte_ready", 32'(byte_ready_o), 32'(!m_pend));
        chk("model_word_valid", 32'(word_valid_o), 32'(m_wv));
        chk("model_word_data", word_data_o, m_wd);
        chk("model_word_nbytes", 32'(word_nbytes_o), 32'(m_nb));
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit l, input bit f);
        byte_valid_i = v; byte_data_i = d; byte_last_i = l; flush_i = f;
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        last;
        logic        flush;
        logic        wr;
        logic        rdy;
        logic        wv;
        logic [31:0] wd;
        logic [2:0]  nb;
    } vec_t;

    vec_t tbl[18];
    int   first_k, nwords, rdylow;

    initial begin
        // inputs {v, d, last, flush, wr} -> outputs after the edge {rdy, wv, wd, nb}
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 3'd4};
        tbl[4]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44332211, 3'd4};
        tbl[5]  = '{1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000BBAA, 3'd2};
        tbl[6]  = '{1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000BBAA, 3'd2};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h000000CC, 3'd1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000000CC, 3'd1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000CC, 3'd1};
        tbl[10] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000CC, 3'd1};
        tbl[11] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000CC, 3'd1};
        tbl[12] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00030201, 3'd3};
        tbl[13] = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00030201, 3'd3};
        tbl[14] = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00030201, 3'd3};
        tbl[15] = '{1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00030201, 3'd3};
        tbl[16] = '{1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40302010, 3'd4};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40302010, 3'd4};

        // Reset state
        rst_ni = 1'b0; timeout_i = 16'd0; word_ready_i = 1'b1;
        drive(0, 8'h00, 0, 0);
        step(); step();
        chk("reset_byte_ready", 32'(byte_ready_o), 32'd1);
        chk("reset_word_valid", 32'(word_valid_o), 32'd0);
        chk("reset_word_data", word_data_o, 32'd0);
        chk("reset_word_nbytes", 32'(word_nbytes_o), 32'd0);
        rst_ni = 1'b1;

        // Directed vector table
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].flush);
            word_ready_i = tbl[i].wr;
            step();
            chk($sformatf("tbl%0d_byte_ready", i), 32'(byte_ready_o), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_word_valid", i), 32'(word_valid_o), 32'(tbl[i].wv));
            chk($sformatf("tbl%0d_word_data", i), word_data_o, tbl[i].wd);
            chk($sformatf("tbl%0d_word_nbytes", i), 32'(word_nbytes_o), 32'(tbl[i].nb));
        end

        // 12 back-to-back bytes: three words, ready never drops
        nwords = 0; rdylow = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1, 8'(8'h60 + i), 0, 0);
            step();
            if (!byte_ready_o) rdylow++;
            if (word_valid_o) nwords++;
        end
        drive(0, 8'h00, 0, 0);
        chk("stream12_words", 32'(nwords), 32'd3);
        chk("stream12_ready_low", 32'(rdylow), 32'd0);
        chk("stream12_last_word", word_data_o, 32'h6B6A6968);
        step();

        // Idle timeout of 8: word valid exactly 8 edges after the accept
        timeout_i = 16'd8;
        drive(1, 8'h5A, 0, 0);
        step();
        drive(0, 8'h00, 0, 0);
        first_k = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (word_valid_o && first_k == 0) first_k = k;
        end
        chk("timeout8_latency", 32'(first_k), 32'd8);
        chk("timeout8_data", word_data_o, 32'h0000005A);
        chk("timeout8_nbytes", 32'(word_nbytes_o), 32'd1);

        // Timeout disabled: a held byte stays put
        timeout_i = 16'd0;
        drive(1, 8'h77, 0, 0);
        step();
        drive(0, 8'h00, 0, 0);
        nwords = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (word_valid_o) nwords++;
        end
        chk("timeout0_no_word", 32'(nwords), 32'd0);
        drive(0, 8'h00, 0, 1);
        step();
        drive(0, 8'h00, 0, 0);
        chk("timeout0_flush_word", word_data_o, 32'h00000077);
        step();

        // Backpressure: first word held, second goes pending, bytes stall
        word_ready_i = 1'b0;
        for (int b = 1; b <= 8; b++) begin
            drive(1, 8'(b), 0, 0);
            step();
            if (b == 4) chk("bp_first_word", word_data_o, 32'h04030201);
        end
        chk("bp_ready_low", 32'(byte_ready_o), 32'd0);
        chk("bp_valid_held", 32'(word_valid_o), 32'd1);
        chk("bp_data_held", word_data_o, 32'h04030201);
        drive(1, 8'h09, 0, 0);
        step(); step();
        chk("bp_byte9_blocked", 32'(byte_ready_o), 32'd0);
        drive(0, 8'h00, 0, 0);
        word_ready_i = 1'b1;
        step();
        chk("bp_pending_loaded", word_data_o, 32'h08070605);
        chk("bp_ready_back", 32'(byte_ready_o), 32'd1);
        chk("bp_valid_second", 32'(word_valid_o), 32'd1);
        step();
        chk("bp_drained", 32'(word_valid_o), 32'd0);

        // Reset while a word is in the output slot and 2 bytes are pending
        word_ready_i = 1'b0;
        for (int b = 0; b < 6; b++) begin
            drive(1, 8'(8'hC0 + b), 0, 0);
            step();
        end
        drive(0, 8'h00, 0, 1);
        step();
        drive(0, 8'h00, 0, 0);
        chk("rst_pre_pending", 32'(byte_ready_o), 32'd0);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        chk("rst_mid_valid", 32'(word_valid_o), 32'd0);
        chk("rst_mid_data", word_data_o, 32'd0);
        chk("rst_mid_nbytes", 32'(word_nbytes_o), 32'd0);
        chk("rst_mid_ready", 32'(byte_ready_o), 32'd1);
        word_ready_i = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            drive(1, 8'(8'hA0 + b), 0, 0);
            step();
        end
        drive(0, 8'h00, 0, 0);
        chk("rst_clean_word", word_data_o, 32'hA4A3A2A1);
        chk("rst_clean_nbytes", 32'(word_nbytes_o), 32'd4);

        // Randomized traffic against the model, several timeout settings
        for (int p = 0; p < 4; p++) begin
            case (p)
                0: timeout_i = 16'd0;
                1: timeout_i = 16'd1;
                2: timeout_i = 16'd3;
                default: timeout_i = 16'd8;
            endcase
            rst_ni = 1'b0;
            drive(0, 8'h00, 0, 0);
            step();
            rst_ni = 1'b1;
            for (int c = 0; c < 700; c++) begin
                drive($urandom_range(0, 2) != 0, 8'($urandom),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
                if (p >= 2) byte_valid_i = ($urandom_range(0, 3) == 0);
                word_ready_i = ($urandom_range(0, 3) != 0);
                rst_ni = ($urandom_range(0, 499) != 0);
                step();
            end
        end
        rst_ni = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
